// File: rtl/mem_cmd_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_cmd_responder_pkg
//  Description : Shared bus definitions for the command-bus control FSMs:
//                bus IDs, opcode encodings, command-word field positions,
//                field-extraction helpers and the responder state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_cmd_responder_pkg;

    // Bus agent IDs
    localparam logic [1:0] c_BUS_ID_0 = 2'b00;
    localparam logic [1:0] c_BUS_ID_1 = 2'b01;
    localparam logic [1:0] c_BUS_ID_2 = 2'b10;
    localparam logic [1:0] c_BUS_ID_3 = 2'b11;

    // Opcode encodings
    localparam logic [1:0] c_OP_NOP   = 2'b00;
    localparam logic [1:0] c_OP_READ  = 2'b01;
    localparam logic [1:0] c_OP_WRITE = 2'b10;
    localparam logic [1:0] c_OP_HASH  = 2'b11;

    // Command-word layout: [ADDRW+7:8] addr, [7:6] flags, [5:4] dest,
    // [3:2] src, [1:0] opcode. The low byte is the control byte.
    localparam int c_CMD_OP_LSB    = 0;
    localparam int c_CMD_SRC_LSB   = 2;
    localparam int c_CMD_DEST_LSB  = 4;
    localparam int c_CMD_FLAGS_LSB = 6;
    localparam int c_CMD_ADDR_LSB  = 8;

    // Responder state encoding; unused codes 6/7 are treated as illegal.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_SEND = 3'd2,
        ST_WR_RECV = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_ACK     = 3'd5
    } state_t;

    function automatic logic [1:0] cmd_op(input logic [7:0] ctl);
        return ctl[c_CMD_OP_LSB +: 2];
    endfunction

    function automatic logic [1:0] cmd_src(input logic [7:0] ctl);
        return ctl[c_CMD_SRC_LSB +: 2];
    endfunction

    function automatic logic [1:0] cmd_dest(input logic [7:0] ctl);
        return ctl[c_CMD_DEST_LSB +: 2];
    endfunction

endpackage : mem_cmd_responder_pkg
`default_nettype wire

// File: rtl/mem_cmd_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_cmd_responder_if
//  Description : Bus bundle around the memory command responder.
//                  cmd_valid/cmd_data   command strobe and word
//                  busy/ack_out         status and completion event
//                  mem_*                single-byte memory access port
//                  tx_*                 byte stream to the destination
//                  rx_*                 byte stream from the source
//                slave  : the responder's view
//                master : the surrounding system's view
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_cmd_responder_if #(
    parameter int ADDRW = 24
);
    logic             cmd_valid;
    logic [ADDRW+7:0] cmd_data;
    logic             busy;
    logic [2:0]       ack_out;

    logic             mem_req;
    logic             mem_we;
    logic [ADDRW-1:0] mem_addr;
    logic [7:0]       mem_wdata;
    logic             mem_ack;
    logic [7:0]       mem_rdata;

    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;

    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;

    modport slave (
        input  cmd_valid, cmd_data, mem_ack, mem_rdata, tx_ready, rx_valid, rx_data,
        output busy, ack_out, mem_req, mem_we, mem_addr, mem_wdata, tx_valid, tx_data, rx_ready
    );

    modport master (
        output cmd_valid, cmd_data, mem_ack, mem_rdata, tx_ready, rx_valid, rx_data,
        input  busy, ack_out, mem_req, mem_we, mem_addr, mem_wdata, tx_valid, tx_data, rx_ready
    );
endinterface : mem_cmd_responder_if
`default_nettype wire

// File: rtl/mem_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_cmd_responder
//  Description : Memory-side command responder. Accepts READ commands whose
//                source is this ID (memory -> tx stream) and WRITE commands
//                whose destination is this ID (rx stream -> memory), moving
//                XFER_BYTES single bytes and then pulsing ack_out.
//  Ports       : clk, rst_n (async, active-low)
//                bus : mem_cmd_responder_if.slave (command, status, memory,
//                      tx and rx streams)
//  Parameters  : ADDRW      byte-address width
//                MEM_ID     this responder's bus ID
//                XFER_BYTES bytes per command (1..64)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_cmd_responder
    import mem_cmd_responder_pkg::*;
#(
    parameter int         ADDRW      = 24,
    parameter logic [1:0] MEM_ID     = 2'b00,
    parameter int         XFER_BYTES = 32
) (
    input  wire                  clk,
    input  wire                  rst_n,
    mem_cmd_responder_if.slave   bus
);

    // 7 bits holds the final count of a 64-byte transfer
    localparam logic [6:0] c_LAST = 7'(XFER_BYTES);

    state_t           r_state;
    logic [6:0]       r_count;
    logic [ADDRW-1:0] r_base;
    logic             r_busy;
    logic [2:0]       r_ack;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [ADDRW-1:0] r_mem_addr;
    logic [7:0]       r_mem_wdata;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;
    logic             r_rx_ready;

    logic [7:0]       w_ctl;
    logic [ADDRW-1:0] w_cmd_addr;
    logic             w_start_rd;
    logic             w_start_wr;
    logic [6:0]       w_count_inc;
    logic             w_last;
    logic [ADDRW-1:0] w_addr_cur;
    logic [ADDRW-1:0] w_addr_next;

    assign w_ctl      = bus.cmd_data[7:0];
    assign w_cmd_addr = bus.cmd_data[ADDRW+7:c_CMD_ADDR_LSB];

    // The IDs are only meaningful at decode time: they select whether this
    // responder owns the command and are not needed once it is running.
    assign w_start_rd = bus.cmd_valid && (cmd_op(w_ctl) == c_OP_READ)  && (cmd_src(w_ctl)  == MEM_ID);
    assign w_start_wr = bus.cmd_valid && (cmd_op(w_ctl) == c_OP_WRITE) && (cmd_dest(w_ctl) == MEM_ID);

    assign w_count_inc = r_count + 7'd1;
    assign w_last      = (w_count_inc == c_LAST);

    // Truncation to ADDRW bits gives the modulo-2^ADDRW wrap.
    assign w_addr_cur  = r_base + ADDRW'(r_count);
    assign w_addr_next = r_base + ADDRW'(w_count_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_base      <= '0;
            r_busy      <= 1'b0;
            r_ack       <= 3'b000;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_rx_ready  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 3'b000;
                    if (w_start_rd) begin
                        // Request goes out on the very next cycle.
                        r_state    <= ST_RD_REQ;
                        r_busy     <= 1'b1;
                        r_base     <= w_cmd_addr;
                        r_count    <= '0;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_cmd_addr;
                    end else if (w_start_wr) begin
                        r_state    <= ST_WR_RECV;
                        r_busy     <= 1'b1;
                        r_base     <= w_cmd_addr;
                        r_count    <= '0;
                        r_rx_ready <= 1'b1;
                    end
                end

                ST_RD_REQ: begin
                    if (bus.mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= bus.mem_rdata;
                        r_state    <= ST_RD_SEND;
                    end
                end

                ST_RD_SEND: begin
                    if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_count    <= w_count_inc;
                        if (w_last) begin
                            r_state <= ST_ACK;
                            r_ack   <= {1'b1, MEM_ID};
                        end else begin
                            r_state    <= ST_RD_REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_addr_next;
                        end
                    end
                end

                ST_WR_RECV: begin
                    if (bus.rx_valid) begin
                        r_rx_ready  <= 1'b0;
                        r_mem_wdata <= bus.rx_data;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_addr_cur;
                        r_state     <= ST_WR_REQ;
                    end
                end

                ST_WR_REQ: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_count   <= w_count_inc;
                        if (w_last) begin
                            r_state <= ST_ACK;
                            r_ack   <= {1'b1, MEM_ID};
                        end else begin
                            r_state    <= ST_WR_RECV;
                            r_rx_ready <= 1'b1;
                        end
                    end
                end

                ST_ACK: begin
                    r_ack   <= 3'b000;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    // Unreachable encodings: drop everything and go idle.
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_ack      <= 3'b000;
                    r_mem_req  <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_rx_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.ack_out   = r_ack;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.tx_data   = r_tx_data;
    assign bus.rx_ready  = r_rx_ready;

endmodule : mem_cmd_responder
`default_nettype wire

// File: doc/mem_cmd_responder.md
MEM_CMD_RESPONDER -- requirements
Module: mem_cmd_responder

Interface
REQ-001 Parameter ADDRW, default 24, SHALL set the byte-address width.
REQ-002 Parameter MEM_ID, default 2'b00, SHALL set this responder's bus ID.
REQ-003 Parameter XFER_BYTES, default 32, SHALL set the bytes moved per command (1..64).
REQ-004 clk  input  1  clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  arbiter-qualified one-cycle strobe: cmd_data is valid.
REQ-007 cmd_data  input  ADDRW+8  command word: [ADDRW+7:8] addr, [7:6] flags, [5:4] dest ID, [3:2] src ID, [1:0] opcode.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 ack_out  output  3  completion event {1'b1, MEM_ID}; 3'b000 otherwise.
REQ-010 mem_req / mem_we / mem_addr[ADDRW-1:0] / mem_wdata[7:0]  outputs  single-byte memory access request.
REQ-011 mem_ack  input  1  access done; mem_rdata[7:0] input valid in the same cycle for reads.
REQ-012 tx_valid / tx_data[7:0]  outputs, tx_ready  input  byte stream to the destination.
REQ-013 rx_valid / rx_data[7:0]  inputs, rx_ready  output  byte stream from the source.

Function
REQ-014 Accept a command only in IDLE on cmd_valid; cmd_valid in any other state SHALL be ignored.
REQ-015 Opcode 2'b01 with src == MEM_ID SHALL start a READ; opcode 2'b10 with dest == MEM_ID SHALL start a WRITE; all others (incl. 2'b11 hash, 2'b00) SHALL be ignored with no ack.
REQ-016 On accept, register addr and dest/src; byte counter cleared to 0.
REQ-017 States: IDLE, RD_REQ, RD_SEND, WR_RECV, WR_REQ, ACK.
REQ-018 RD_REQ: mem_req=1, mem_we=0, mem_addr=base+count; on mem_ack capture mem_rdata, go RD_SEND.
REQ-019 RD_SEND: tx_valid=1 with captured byte; on tx_ready, count+1; if count reaches XFER_BYTES go ACK, else RD_REQ.
REQ-020 WR_RECV: rx_ready=1; on rx_valid capture rx_data, go WR_REQ.
REQ-021 WR_REQ: mem_req=1, mem_we=1, mem_wdata=captured byte, mem_addr=base+count; on mem_ack count+1; at XFER_BYTES go ACK, else WR_RECV.
REQ-022 mem_req, tx_valid SHALL stay asserted with stable addr/data until their handshake completes.
REQ-023 Address arithmetic SHALL be modulo 2^ADDRW (wrap from all-ones to 0).
REQ-024 ACK: ack_out={1'b1, MEM_ID} for exactly one cycle, then IDLE; a new cmd_valid may be accepted the cycle after ACK.
REQ-025 Command-accept to first mem_req SHALL be 1 cycle; each byte costs mem-latency + 1 cycle minimum.
REQ-026 tx_valid, rx_ready, mem_req SHALL never be asserted in IDLE or ACK.
REQ-027 Illegal state encodings SHALL return to IDLE.

Reset
REQ-028 Reset SHALL force IDLE, counter 0, busy=0, ack_out=0, mem_req=0, mem_we=0, tx_valid=0, rx_ready=0, all address/data outputs 0.
REQ-029 Reset mid-transfer SHALL abandon the command with no ack; partial memory writes are not undone.

Structure
REQ-030 Bus IDs, opcode encodings (2'b01 read, 2'b10 write, 2'b11 hash) and command-field bit positions SHALL live in the shared bus package used by all control FSMs.
REQ-031 Implementation SHALL be one module; no sub-module.

Verification
REQ-032 READ: cmd addr=0x000100, dest=01, src=00, op=01; mem_ack 1 cycle after each req, tx_ready=1 -> 32 bytes from 0x000100..0x00011F on tx, then ack_out=3'b100 one cycle.
REQ-033 WRITE: cmd addr=0x000200, dest=00, src=01, op=10; 32 rx bytes 0x00..0x1F -> mem writes addr 0x000200+i data i, then ack_out=3'b100.
REQ-034 Ignore: op=11 dest=01, and op=01 src=01 -> busy stays 0, no mem_req, no ack.
REQ-035 Backpressure/wrap: READ at 0xFFFFF0 with tx_ready toggling 1/0 -> addresses wrap to 0x000000 after 0xFFFFFF, no byte lost/duplicated, tx_data stable while stalled.
REQ-036 Second cmd_valid mid-READ -> ignored; rst_n low at byte 10 -> IDLE, all outputs 0, no ack; next command completes normally.
